// File: rtl/acc_pkg.sv
// acc_feed shared definitions.
// Operand width default, burst length width, FSM states.
package acc_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LEN_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/acc_fifo.sv
// acc_fifo: circular word buffer feeding acc_feed.
// Head word is visible on dout whenever not empty.
module acc_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // Storage write; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/acc_feed.sv
// acc_feed: buffers upstream words and issues bursts of len
// words to an accumulator as registered x/en.
module acc_feed
  import acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic [WIDTH-1:0]       x,
  output logic                   en,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             pop;

  assign in_ready = !full;
  assign busy     = (state != IDLE);
  assign pop      = (state == RUN) && !empty;

  acc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Burst FSM with registered operand, strobe and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      x         <= '0;
      en        <= 1'b0;
      done      <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              state     <= RUN;
            end else begin
              state <= FIN;
            end
          end
        end
        RUN: begin
          if (!empty) begin
            x         <= head;
            en        <= 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_feed.md
ACC_FEED -- requirements
Module: acc_feed

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 Parameter WIDTH, default 32, data width; matches accumulator operand width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 start  input  1  one-cycle pulse: begin a burst of len words.
REQ-009 len  input  16  burst length, sampled with start.
REQ-010 x  output  WIDTH  operand to accumulator, registered.
REQ-011 en  output  1  x valid this cycle, accumulator adds x at the next posedge; registered.
REQ-012 busy  output  1  burst in progress.
REQ-013 done  output  1  one-cycle pulse after the last word of a burst is issued.
REQ-014 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 in_ready SHALL equal !full, from registered state only, with no combinational path from any input.
REQ-016 A push SHALL occur at a posedge where in_valid && in_ready; in_data is written at the tail.
REQ-017 FSM states SHALL be IDLE, RUN, FIN.
REQ-018 IDLE: no pops; en=0; on start with len!=0, capture remaining=len and go to RUN; on start with len==0, go to FIN.
REQ-019 RUN: at each posedge with FIFO non-empty, pop the head into x, set en=1 and decrement remaining; with FIFO empty, set en=0 and leave x unchanged.
REQ-020 RUN SHALL go to FIN at the posedge that issues the word bringing remaining to 0.
REQ-021 FIN: en=0, done=1 for exactly one cycle, then go to IDLE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 busy SHALL be 1 in RUN and FIN, 0 in IDLE.
REQ-024 Latency: a word pushed at posedge N into an empty FIFO while in RUN SHALL appear on x with en=1 in the cycle following posedge N+1.
REQ-025 A simultaneous push and pop SHALL leave level unchanged; push-when-full is impossible by REQ-015.
REQ-026 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-027 Words SHALL issue in FIFO order, with no loss or duplication.
REQ-028 x SHALL hold its last value while en=0.
REQ-029 Words remaining in the FIFO after FIN SHALL stay queued for the next burst.

Reset
REQ-030 Asserting rst SHALL immediately force: state=IDLE, FIFO empty (level=0), x=0, en=0, busy=0, done=0, remaining=0, in_ready=1.
REQ-031 Reset mid-burst SHALL discard queued words and the remaining count; no done pulse SHALL be produced.
REQ-032 The first push SHALL be accepted at the first posedge after rst deasserts.

Structure
REQ-033 A shared package acc_pkg SHALL hold the WIDTH default, the len width constant, and the FSM state enum (IDLE, RUN, FIN).
REQ-034 Storage SHALL live in one sub-module, acc_fifo (push/pop/full/empty/level, parameterised on DEPTH and WIDTH).
REQ-035 acc_feed SHALL contain the FSM, the remaining counter and the x/en output registers, and SHALL instantiate acc_fifo.

Verification
REQ-036 Reset, push 0..9 back-to-back, start with len=10 -> en high for 10 cycles, x=0..9 in order, one done pulse; a downstream acc reads q=45.
REQ-037 Push DEPTH+2 words with no start -> in_ready=0 once level=4; extra words held off; level stays 4.
REQ-038 start with len=3, push 7, 8, 9 with one idle cycle between each -> en pattern shows bubbles; x=7, 8, 9; done one cycle after the word 9 issues.
REQ-039 start with len=0 -> FIN next cycle, done pulse, no en.
REQ-040 Assert rst mid-burst with level=3 -> level=0, en=0 and busy=0 immediately; no done pulse.
REQ-041 Push 5 words, start with len=2 -> 2 issued, 3 remain (level=3); second start with len=3 issues the rest in order.
